// File: rtl/vpu_issue_ctrl.sv
// vpu_issue_ctrl
// In-order issue/completion tracker placed ahead of the VPU execution delay
// counters. Accepted ops fire a one-cycle start toward the execution lane and
// are held in a circular in-flight queue until their latency has elapsed.
// Completions are presented to writeback strictly in issue order.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   flush_i                    discard all in-flight ops (overrides push/pop)
//   req_valid_i/req_ready_o    decoder handshake; ready ignores wb_ready_i
//   req_opcode_i/tag_i/delay_i decoded op fields
//   exe_start_o/opcode_o/delay_o  start pulse and pass-through op fields
//   wb_valid_o/wb_ready_i      head-complete handshake toward writeback
//   wb_tag_o/wb_opcode_o       head entry fields
//   inflight_o, busy_o         occupancy and non-empty flag
//
// Build option: define VPU_ISSUE_STATS_EN to add stat_issue_o (accept count)
// and stat_stall_o (cycles with valid but not ready), both 32-bit wrapping,
// cleared by reset only.
module vpu_issue_ctrl #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 5,
    parameter int OPCODE_W = 4,
    parameter int DELAY_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [OPCODE_W-1:0]        req_opcode_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    input  logic [DELAY_W-1:0]         req_delay_i,
    output logic                       exe_start_o,
    output logic [OPCODE_W-1:0]        exe_opcode_o,
    output logic [DELAY_W-1:0]         exe_delay_o,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [TAG_W-1:0]           wb_tag_o,
    output logic [OPCODE_W-1:0]        wb_opcode_o,
    output logic [$clog2(DEPTH):0]     inflight_o,
`ifdef VPU_ISSUE_STATS_EN
    output logic [31:0]                stat_issue_o,
    output logic [31:0]                stat_stall_o,
`endif
    output logic                       busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {EMPTY, WAIT, COMPLETE} state_t;

    state_t state, state_next;

    logic [TAG_W-1:0]    tag_q    [DEPTH];
    logic [OPCODE_W-1:0] opcode_q [DEPTH];
    logic [DELAY_W-1:0]  rem_q    [DEPTH];

    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_inc;
    logic [CNT_W-1:0]   count;
    logic               accept, pop;
    logic [DELAY_W-1:0] init_rem;
    logic [DELAY_W-1:0] head_rem_next;
    logic               head_next_exists;

    function automatic logic [DELAY_W-1:0] sat_dec(input logic [DELAY_W-1:0] v);
        return (v == '0) ? v : v - DELAY_W'(1);
    endfunction

    // Ready also drops during reset so no start can leak out of a reset cycle.
    assign req_ready_o  = rst_n && (count != CNT_W'(DEPTH)) && !flush_i;
    assign accept       = req_valid_i && req_ready_o;
    assign pop          = wb_valid_o && wb_ready_i && !flush_i;
    assign init_rem     = (req_delay_i == '0) ? '0 : req_delay_i - DELAY_W'(1);
    assign rd_inc       = rd_ptr + PTR_W'(1);

    assign exe_start_o  = accept;
    assign exe_opcode_o = req_opcode_i;
    assign exe_delay_o  = req_delay_i;

    assign wb_valid_o   = (state == COMPLETE);
    assign wb_tag_o     = tag_q[rd_ptr];
    assign wb_opcode_o  = opcode_q[rd_ptr];
    assign inflight_o   = count;
    assign busy_o       = (count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // The registered state tracks the head's post-update remaining count so
    // wb_valid_o comes straight from a flop: after a pop the next head is the
    // entry behind it, or the op being pushed if the queue would otherwise empty.
    always_comb begin
        state_next       = state;
        head_rem_next    = '0;
        head_next_exists = 1'b0;
        if (pop) begin
            if (count > CNT_W'(1)) begin
                head_rem_next    = sat_dec(rem_q[rd_inc]);
                head_next_exists = 1'b1;
            end else if (accept) begin
                head_rem_next    = init_rem;
                head_next_exists = 1'b1;
            end
        end else if (count != '0) begin
            head_rem_next    = sat_dec(rem_q[rd_ptr]);
            head_next_exists = 1'b1;
        end else if (accept) begin
            head_rem_next    = init_rem;
            head_next_exists = 1'b1;
        end
        if (flush_i || !head_next_exists) state_next = EMPTY;
        else if (head_rem_next == '0)     state_next = COMPLETE;
        else                              state_next = WAIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[PTR_W'(i)]    <= '0;
                opcode_q[PTR_W'(i)] <= '0;
                rem_q[PTR_W'(i)]    <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Free slots count down too; harmless since a push overwrites them.
            for (int unsigned i = 0; i < DEPTH; i++)
                rem_q[PTR_W'(i)] <= sat_dec(rem_q[PTR_W'(i)]);
            if (accept) begin
                tag_q[wr_ptr]    <= req_tag_i;
                opcode_q[wr_ptr] <= req_opcode_i;
                rem_q[wr_ptr]    <= init_rem;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_inc;
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef VPU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issue_o <= '0;
            stat_stall_o <= '0;
        end else begin
            if (accept)                      stat_issue_o <= stat_issue_o + 32'd1;
            if (req_valid_i && !req_ready_o) stat_stall_o <= stat_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// Directed testbench for vpu_issue_ctrl: single op, in-order completion,
// full queue with backpressure, zero delay, flush, reset mid-operation and,
// when VPU_ISSUE_STATS_EN is defined, the statistics counters.
module tb_vpu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [3:0] req_opcode_i;
    logic [4:0] req_tag_i;
    logic [3:0] req_delay_i;
    logic       exe_start_o;
    logic [3:0] exe_opcode_o;
    logic [3:0] exe_delay_o;
    logic       wb_valid_o;
    logic       wb_ready_i;
    logic [4:0] wb_tag_o;
    logic [3:0] wb_opcode_o;
    logic [2:0] inflight_o;
    logic       busy_o;
`ifdef VPU_ISSUE_STATS_EN
    logic [31:0] stat_issue_o;
    logic [31:0] stat_stall_o;
`endif

    int checks = 0;
    int errors = 0;

    vpu_issue_ctrl #(.DEPTH(4), .TAG_W(5), .OPCODE_W(4), .DELAY_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_opcode_i (req_opcode_i),
        .req_tag_i    (req_tag_i),
        .req_delay_i  (req_delay_i),
        .exe_start_o  (exe_start_o),
        .exe_opcode_o (exe_opcode_o),
        .exe_delay_o  (exe_delay_o),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_tag_o     (wb_tag_o),
        .wb_opcode_o  (wb_opcode_o),
        .inflight_o   (inflight_o),
`ifdef VPU_ISSUE_STATS_EN
        .stat_issue_o (stat_issue_o),
        .stat_stall_o (stat_stall_o),
`endif
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then changed at posedge+1 and outputs
    // checked at posedge+2, well away from both clock edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] tag, input logic [3:0] op,
                         input logic [3:0] dly);
        req_valid_i  = v;
        req_tag_i    = tag;
        req_opcode_i = op;
        req_delay_i  = dly;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        req_valid_i = 1'b0; req_tag_i = '0; req_opcode_i = '0; req_delay_i = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        // Reset state
        chk("rst_ready",    req_ready_o, 1);
        chk("rst_start",    exe_start_o, 0);
        chk("rst_wbvalid",  wb_valid_o,  0);
        chk("rst_wbtag",    wb_tag_o,    0);
        chk("rst_wbop",     wb_opcode_o, 0);
        chk("rst_inflight", inflight_o,  0);
        chk("rst_busy",     busy_o,      0);

        // Single op: tag 5, delay 3
        drive(1, 5'd5, 4'd7, 4'd3);
        chk("s_start", exe_start_o, 1);
        chk("s_exeop", exe_opcode_o, 7);
        chk("s_exedly", exe_delay_o, 3);
        tick(); drive(0, 0, 0, 0);
        chk("s_c1_valid", wb_valid_o, 0);
        chk("s_c1_inflight", inflight_o, 1);
        chk("s_c1_start", exe_start_o, 0);
        tick(); #1;
        chk("s_c2_valid", wb_valid_o, 0);
        tick(); #1;
        chk("s_c3_valid", wb_valid_o, 1);
        chk("s_c3_tag", wb_tag_o, 5);
        chk("s_c3_op", wb_opcode_o, 7);
        tick(); #1;
        chk("s_c4_busy", busy_o, 0);
        chk("s_c4_valid", wb_valid_o, 0);

        // In-order completion: tag 1 delay 6, then tag 2 delay 1
        drive(1, 5'd1, 4'd1, 4'd6);
        chk("o_start1", exe_start_o, 1);
        tick(); drive(1, 5'd2, 4'd2, 4'd1);
        chk("o_start2", exe_start_o, 1);
        chk("o_c1_valid", wb_valid_o, 0);
        tick(); drive(0, 0, 0, 0);
        for (int c = 2; c <= 5; c++) begin
            chk("o_wait_valid", wb_valid_o, 0);
            tick(); #1;
        end
        chk("o_c6_valid", wb_valid_o, 1);
        chk("o_c6_tag", wb_tag_o, 1);
        tick(); #1;
        chk("o_c7_valid", wb_valid_o, 1);
        chk("o_c7_tag", wb_tag_o, 2);
        chk("o_c7_op", wb_opcode_o, 2);
        tick(); #1;
        chk("o_c8_busy", busy_o, 0);

        // Full queue under backpressure
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(10 + i), 4'(i), 4'd1);
            chk("f_start", exe_start_o, 1);
            tick();
        end
        drive(1, 5'd14, 4'd9, 4'd1);
        chk("f_ready", req_ready_o, 0);
        chk("f_nostart", exe_start_o, 0);
        chk("f_inflight", inflight_o, 4);
        chk("f_valid", wb_valid_o, 1);
        chk("f_tag", wb_tag_o, 10);
        tick(); #1;
        chk("f_hold_tag", wb_tag_o, 10);
        chk("f_hold_valid", wb_valid_o, 1);
        chk("f_hold_inflight", inflight_o, 4);
        tick();
        wb_ready_i = 1'b1;
        drive(0, 0, 0, 0);
        chk("f_d0_tag", wb_tag_o, 10);
        chk("f_d0_ready", req_ready_o, 0);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            chk("f_drain_valid", wb_valid_o, 1);
            chk("f_drain_tag", wb_tag_o, 10 + i);
            chk("f_drain_ready", req_ready_o, 1);
            chk("f_drain_inflight", inflight_o, 4 - i);
        end
        tick(); #1;
        chk("f_empty_busy", busy_o, 0);

        // Delay 0 behaves as delay 1
        drive(1, 5'd3, 4'd4, 4'd0);
        chk("z_start", exe_start_o, 1);
        chk("z_exedly", exe_delay_o, 0);
        tick(); drive(0, 0, 0, 0);
        chk("z_valid", wb_valid_o, 1);
        chk("z_tag", wb_tag_o, 3);
        tick(); #1;
        chk("z_busy", busy_o, 0);

        // Flush with 3 in flight and a pending request
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 4'd5, 4'd5);
            tick();
        end
        flush_i = 1'b1;
        drive(1, 5'd23, 4'd6, 4'd2);
        chk("fl_ready", req_ready_o, 0);
        chk("fl_nostart", exe_start_o, 0);
        chk("fl_inflight_pre", inflight_o, 3);
        tick();
        flush_i = 1'b0;
        drive(0, 0, 0, 0);
        chk("fl_inflight", inflight_o, 0);
        chk("fl_valid", wb_valid_o, 0);
        chk("fl_busy", busy_o, 0);
        chk("fl_ready_back", req_ready_o, 1);
        wb_ready_i = 1'b1;

        // Reset in the middle of operation
        wb_ready_i = 1'b0;
        drive(1, 5'd7, 4'd3, 4'd2);
        tick();
        rst_n = 1'b0;
        drive(1, 5'd8, 4'd3, 4'd2);
        chk("r_nostart", exe_start_o, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        chk("r_inflight", inflight_o, 0);
        chk("r_valid", wb_valid_o, 0);
        chk("r_ready", req_ready_o, 1);
        wb_ready_i = 1'b1;

`ifdef VPU_ISSUE_STATS_EN
        // Ten back-to-back accepts with one completion per cycle
        chk("st_issue_rst", stat_issue_o, 0);
        chk("st_stall_rst", stat_stall_o, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(i), 4'd1, 4'd1);
            chk("st_start", exe_start_o, 1);
            if (i > 0) begin
                chk("st_tp_valid", wb_valid_o, 1);
                chk("st_tp_tag", wb_tag_o, i - 1);
            end
            tick();
        end
        drive(0, 0, 0, 0);
        chk("st_last_tag", wb_tag_o, 9);
        tick();
        // Four stall cycles created by flushing while a request is pending
        flush_i = 1'b1;
        drive(1, 5'd30, 4'd0, 4'd1);
        for (int i = 0; i < 4; i++) tick();
        drive(0, 0, 0, 0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("st_issue", stat_issue_o, 10);
        chk("st_stall", stat_stall_o, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vpu_issue_ctrl.md
# vpu_issue_ctrl

In-order issue/completion tracker that sits directly upstream of the VPU execution delay counters. It accepts decoded vector ops from the decoder, fires a one-cycle start with the op's latency toward the execution lane, and holds each op's tag in a small in-flight queue until its latency has elapsed. It then presents completions to writeback strictly in issue order, under valid/ready backpressure.

## Interface
- `DEPTH`, 4, in-flight queue entries (power of two, ≥2)
- `TAG_W`, 5, destination tag width
- `OPCODE_W`, 4, opcode width
- `DELAY_W`, 4, latency field width (matches `VPU_PKG::MAX_DELAY_LG2`)

Reset is `rst_n`, synchronous, active-low; the clock is `clk`.

- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `flush_i`  in  1  discard all in-flight ops
- `req_valid_i`  in  1  decoder has an op
- `req_ready_o`  out  1  op accepted this cycle when high with valid
- `req_opcode_i`  in  OPCODE_W  op code
- `req_tag_i`  in  TAG_W  destination tag
- `req_delay_i`  in  DELAY_W  op latency in cycles
- `exe_start_o`  out  1  one-cycle start pulse to execution lane
- `exe_opcode_o`  out  OPCODE_W  opcode for the started op
- `exe_delay_o`  out  DELAY_W  latency for the started op
- `wb_valid_o`  out  1  head op complete
- `wb_ready_i`  in  1  writeback accepts
- `wb_tag_o`  out  TAG_W  head tag
- `wb_opcode_o`  out  OPCODE_W  head opcode
- `inflight_o`  out  $clog2(DEPTH)+1  occupied entries
- `busy_o`  out  1  inflight_o != 0

## Operation
- **Queue:** circular buffer with wrapping read and write pointers plus an occupancy counter. Each entry holds {tag, opcode, remaining}, with `remaining` being DELAY_W bits.
- **Accept:** an op is accepted when `req_valid_i && req_ready_o`.
- **Ready:** `req_ready_o = (inflight_o != DEPTH) && !flush_i`. It is never a function of `wb_ready_i`, so there is no push-through on full.
- **On accept:**
  - Write the entry with `remaining = max(req_delay_i,1) - 1`.
  - In the same cycle, drive `exe_start_o=1` and pass the opcode and delay through combinationally.
  - A delay of 0 is treated as 1.
- **Countdown:** every cycle, every occupied entry with `remaining != 0` decrements by 1. `remaining` saturates at 0, including while waiting on backpressure.
- **Completion order:**
  - `wb_valid_o = busy_o && head.remaining == 0`.
  - A younger op whose countdown reaches 0 waits behind its head; there is no out-of-order completion.
- **Pop:** `wb_valid_o && wb_ready_i` advances the read pointer.
- **Simultaneous push and pop:** occupancy is unchanged and both pointers advance.
- **Flush:**
  - Next cycle: occupancy is 0, pointers are 0, `wb_valid_o` is 0.
  - Flush overrides pop and push in the same cycle; there is no start pulse on a flush cycle.
- **State:**
  - EMPTY: occupancy 0.
  - WAIT: non-empty, head `remaining != 0`.
  - COMPLETE: head `remaining == 0`.
  - EMPTY→WAIT on accept, or EMPTY→COMPLETE if the accepted delay ≤1 and it becomes head with remaining 0.
  - WAIT→COMPLETE on head countdown.
  - COMPLETE→WAIT/COMPLETE/EMPTY on pop, according to the next head.
  - Any state→EMPTY on flush or reset.

## Timing
- **Reset values:** `req_ready_o=1` (after reset), `exe_start_o=0`, `wb_valid_o=0`, `wb_tag_o=0`, `wb_opcode_o=0`, `inflight_o=0`, `busy_o=0`.
- **Latency:** an op accepted in cycle T with delay d≥1 has `remaining` d−1 in cycle T+1. If it is head with no backpressure, `wb_valid_o` rises in cycle T+d.
- **Throughput:** one accept and one completion per cycle sustained.
- **Output stability:** `wb_tag_o` and `wb_opcode_o` are stable while `wb_valid_o && !wb_ready_i`. `wb_valid_o` does not drop without a pop or flush.
- **Reset mid-operation:** all entries are discarded and no `exe_start_o` is issued in the reset cycle.

## Configuration
- **`VPU_ISSUE_STATS_EN`** defined: adds two outputs.
  - `stat_issue_o` (32): count of accepts.
  - `stat_stall_o` (32): cycles with `req_valid_i && !req_ready_o`.
  - Both wrap at 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- **Single op:** reset, accept tag 5 with delay 3 at cycle 0. Required: `exe_start_o` pulses in cycle 0, `wb_valid_o` rises in cycle 3 with tag 5, and `busy_o` is 0 in cycle 4.
- **In-order completion:** accept tag 1 delay 6, then tag 2 delay 1 on the next cycle.
  - Tag 2's countdown finishes first, but `wb_valid_o` stays low until cycle 6.
  - Tag 1 completes in cycle 6, then tag 2 completes in cycle 7.
- **Full:** with `wb_ready_i=0`, push 4 ops of delay 1. Then:
  - `req_ready_o=0`, `inflight_o=4`, and `wb_tag_o` stays at the first tag.
  - Raise `wb_ready_i`: four back-to-back completions in order, and `req_ready_o` returns in the cycle after the first pop.
- **Delay 0:** accept delay 0. Required: completion timing is identical to delay 1 (`wb_valid_o` in the next cycle).
- **Flush:** with 3 in-flight ops and `req_valid_i=1`, assert `flush_i` for one cycle. Required: no accept and no `exe_start_o` that cycle, and the next cycle has `inflight_o=0` and `wb_valid_o=0`.
- **Stats (macro on):** 10 accepts plus 4 stall cycles. Required: `stat_issue_o=10` and `stat_stall_o=4`, both unchanged by a flush.
